// File: rtl/vga_vtim_meas.sv
// vga_vtim_meas: recovers sync duration, gate delay, gate length and total
// length from an observed Sync/Gate pair on one video axis. Each value is
// reported as N-1, matching the programming format of the timing generator.
module vga_vtim_meas #(
    parameter logic SYNC_POL = 1'b1,
    parameter logic GATE_POL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic        Sync,
    input  logic        Gate,
    output logic [7:0]  Tsync,
    output logic [7:0]  Tgdel,
    output logic [15:0] Tgate,
    output logic [15:0] Tlen,
    output logic        Valid,
    output logic        Stable,
    output logic        Err
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SYNC = 3'd1,
        GDEL = 3'd2,
        GATE = 3'd3,
        TAIL = 3'd4
    } state_t;

    // Saturating increment for the short (sync / gate delay) counters.
    function automatic logic [8:0] inc9(input logic [8:0] c);
        if (c == 9'h1FF) begin
            return c;
        end else begin
            return c + 9'd1;
        end
    endfunction

    // Saturating increment for the long (gate / total) counters.
    function automatic logic [16:0] inc17(input logic [16:0] c);
        if (c == 17'h1FFFF) begin
            return c;
        end else begin
            return c + 17'd1;
        end
    endfunction

    // N-1 field; an empty count or one that does not fit reports all-ones.
    function automatic logic [7:0] fld8(input logic [8:0] n);
        if ((n == 9'd0) || (n > 9'd256)) begin
            return 8'hFF;
        end else begin
            return 8'(n - 9'd1);
        end
    endfunction

    function automatic logic [15:0] fld16(input logic [16:0] n);
        if ((n == 17'd0) || (n > 17'd65536)) begin
            return 16'hFFFF;
        end else begin
            return 16'(n - 17'd1);
        end
    endfunction

    state_t      state_q, state_d;
    logic        sp_q, sp_d;
    logic [8:0]  ns_q, ns_d;
    logic [8:0]  nd_q, nd_d;
    logic [16:0] ng_q, ng_d;
    logic [16:0] nl_q, nl_d;
    logic        err_q, err_d;
    logic        have_prev_q, have_prev_d;
    logic [7:0]  tsync_q, tsync_d;
    logic [7:0]  tgdel_q, tgdel_d;
    logic [15:0] tgate_q, tgate_d;
    logic [15:0] tlen_q, tlen_d;
    logic        valid_q, valid_d;
    logic        stable_q, stable_d;
    logic        err_o_q, err_o_d;

    logic        s_s, g_s, start_s, ovf_s, frame_err_s, same_s;
    logic [7:0]  tsync_n_s, tgdel_n_s;
    logic [15:0] tgate_n_s, tlen_n_s;

    assign s_s     = Sync ^ ~SYNC_POL;
    assign g_s     = Gate ^ ~GATE_POL;
    assign start_s = s_s & ~sp_q;

    assign ovf_s = (ns_q > 9'd256) | (nd_q > 9'd256) |
                   (ng_q > 17'd65536) | (nl_q > 17'd65536);
    // A frame ending while still in SYNC or GDEL never showed its gate.
    assign frame_err_s = err_q | ovf_s | (state_q == SYNC) | (state_q == GDEL);

    assign tsync_n_s = fld8(ns_q);
    assign tgdel_n_s = fld8(nd_q);
    assign tgate_n_s = fld16(ng_q);
    assign tlen_n_s  = fld16(nl_q);
    assign same_s    = ({tsync_n_s, tgdel_n_s, tgate_n_s, tlen_n_s} ==
                        {tsync_q, tgdel_q, tgate_q, tlen_q});

    // Next-state logic: phase tracking, counting, and latching at frame start.
    always_comb begin
        state_d     = state_q;
        sp_d        = sp_q;
        ns_d        = ns_q;
        nd_d        = nd_q;
        ng_d        = ng_q;
        nl_d        = nl_q;
        err_d       = err_q;
        have_prev_d = have_prev_q;
        tsync_d     = tsync_q;
        tgdel_d     = tgdel_q;
        tgate_d     = tgate_q;
        tlen_d      = tlen_q;
        valid_d     = 1'b0;
        stable_d    = stable_q;
        err_o_d     = err_o_q;
        if (ena) begin
            sp_d = s_s;
            if (start_s) begin
                if (state_q != IDLE) begin
                    tsync_d     = tsync_n_s;
                    tgdel_d     = tgdel_n_s;
                    tgate_d     = tgate_n_s;
                    tlen_d      = tlen_n_s;
                    err_o_d     = frame_err_s;
                    valid_d     = 1'b1;
                    stable_d    = have_prev_q & same_s & ~frame_err_s & ~err_o_q;
                    have_prev_d = 1'b1;
                end else begin
                    have_prev_d = have_prev_q;
                end
                // The start sample itself is the first sync sample.
                ns_d    = 9'd1;
                nd_d    = 9'd0;
                ng_d    = 17'd0;
                nl_d    = 17'd1;
                err_d   = g_s;
                state_d = SYNC;
            end else begin
                if (state_q != IDLE) begin
                    nl_d = inc17(nl_q);
                end else begin
                    nl_d = nl_q;
                end
                case (state_q)
                    IDLE: begin
                        state_d = IDLE;
                    end
                    SYNC: begin
                        if (s_s) begin
                            ns_d = inc9(ns_q);
                            if (g_s) begin
                                err_d = 1'b1;
                            end else begin
                                err_d = err_q;
                            end
                        end else if (g_s) begin
                            // Sync fall coincides with gate rise: zero delay.
                            err_d   = 1'b1;
                            ng_d    = inc17(ng_q);
                            state_d = GATE;
                        end else begin
                            nd_d    = inc9(nd_q);
                            state_d = GDEL;
                        end
                    end
                    GDEL: begin
                        if (g_s) begin
                            ng_d    = inc17(ng_q);
                            state_d = GATE;
                        end else begin
                            nd_d = inc9(nd_q);
                        end
                    end
                    GATE: begin
                        if (g_s) begin
                            ng_d = inc17(ng_q);
                        end else begin
                            state_d = TAIL;
                        end
                    end
                    TAIL: begin
                        state_d = TAIL;
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end else begin
            sp_d = sp_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sp_q        <= 1'b1;
            ns_q        <= 9'd0;
            nd_q        <= 9'd0;
            ng_q        <= 17'd0;
            nl_q        <= 17'd0;
            err_q       <= 1'b0;
            have_prev_q <= 1'b0;
            tsync_q     <= 8'd0;
            tgdel_q     <= 8'd0;
            tgate_q     <= 16'd0;
            tlen_q      <= 16'd0;
            valid_q     <= 1'b0;
            stable_q    <= 1'b0;
            err_o_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sp_q        <= sp_d;
            ns_q        <= ns_d;
            nd_q        <= nd_d;
            ng_q        <= ng_d;
            nl_q        <= nl_d;
            err_q       <= err_d;
            have_prev_q <= have_prev_d;
            tsync_q     <= tsync_d;
            tgdel_q     <= tgdel_d;
            tgate_q     <= tgate_d;
            tlen_q      <= tlen_d;
            valid_q     <= valid_d;
            stable_q    <= stable_d;
            err_o_q     <= err_o_d;
        end
    end

    assign Tsync  = tsync_q;
    assign Tgdel  = tgdel_q;
    assign Tgate  = tgate_q;
    assign Tlen   = tlen_q;
    assign Valid  = valid_q;
    assign Stable = stable_q;
    assign Err    = err_o_q;

endmodule

// File: tb/tb_vga_vtim_meas.sv
// Bench for vga_vtim_meas: an active-high-sync instance and an active-low-sync
// instance see the same logical frames; a queue-based frame analyser predicts
// every output on every clock.
module tb_vga_vtim_meas;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ena = 1'b0;
    logic sync_a = 1'b0;
    logic gate_a = 1'b0;

    logic [7:0]  p_tsync, p_tgdel, n_tsync, n_tgdel;
    logic [15:0] p_tgate, p_tlen, n_tgate, n_tlen;
    logic        p_valid, p_stable, p_err, n_valid, n_stable, n_err;

    int total = 0;
    int bad = 0;
    int vcnt = 0;

    // reference model state
    bit          m_sp, m_active, m_have_prev;
    bit          q_s[$];
    bit          q_g[$];
    logic [7:0]  e_tsync, e_tgdel;
    logic [15:0] e_tgate, e_tlen;
    logic        e_valid, e_stable, e_err;

    vga_vtim_meas #(.SYNC_POL(1'b1), .GATE_POL(1'b1)) u_dut_p (
        .clk(clk), .rst(rst), .ena(ena), .Sync(sync_a), .Gate(gate_a),
        .Tsync(p_tsync), .Tgdel(p_tgdel), .Tgate(p_tgate), .Tlen(p_tlen),
        .Valid(p_valid), .Stable(p_stable), .Err(p_err));

    vga_vtim_meas #(.SYNC_POL(1'b0), .GATE_POL(1'b1)) u_dut_n (
        .clk(clk), .rst(rst), .ena(ena), .Sync(~sync_a), .Gate(gate_a),
        .Tsync(n_tsync), .Tgdel(n_tgdel), .Tgate(n_tgate), .Tlen(n_tlen),
        .Valid(n_valid), .Stable(n_stable), .Err(n_err));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] clip8(input int n);
        if (n == 0 || n > 256) return 8'hFF;
        return 8'(n - 1);
    endfunction

    function automatic logic [15:0] clip16(input int n);
        if (n == 0 || n > 65536) return 16'hFFFF;
        return 16'(n - 1);
    endfunction

    // Measure one complete frame held in the sample queues.
    task automatic analyze(output logic [7:0] ts, output logic [7:0] td,
                           output logic [15:0] tg, output logic [15:0] tl,
                           output logic er);
        int n, i, j, k, ns, nd, ng;
        bit e;
        n = q_s.size();
        e = 1'b0;
        i = 0;
        while (i < n && q_s[i]) begin
            if (q_g[i]) e = 1'b1;
            i++;
        end
        ns = i;
        nd = 0;
        ng = 0;
        if (i == n) begin
            e = 1'b1;
        end else begin
            j = i;
            while (j < n && !q_g[j]) j++;
            nd = j - i;
            if (nd == 0) e = 1'b1;
            if (j == n) e = 1'b1;
            k = j;
            while (k < n && q_g[k]) k++;
            ng = k - j;
        end
        if (ns > 256 || nd > 256 || ng > 65536 || n > 65536) e = 1'b1;
        ts = clip8(ns);
        td = clip8(nd);
        tg = clip16(ng);
        tl = clip16(n);
        er = e;
    endtask

    task automatic model_reset();
        m_sp = 1'b1;
        m_active = 1'b0;
        m_have_prev = 1'b0;
        q_s.delete();
        q_g.delete();
        e_tsync = 8'd0; e_tgdel = 8'd0; e_tgate = 16'd0; e_tlen = 16'd0;
        e_valid = 1'b0; e_stable = 1'b0; e_err = 1'b0;
    endtask

    task automatic model_step(input logic e, input logic s, input logic g);
        logic [7:0]  ts, td;
        logic [15:0] tg, tl;
        logic        er;
        e_valid = 1'b0;
        if (e) begin
            if (s && !m_sp) begin
                if (m_active) begin
                    analyze(ts, td, tg, tl, er);
                    e_stable = m_have_prev && ({ts, td, tg, tl} == {e_tsync, e_tgdel, e_tgate, e_tlen})
                               && !er && !e_err;
                    e_tsync = ts; e_tgdel = td; e_tgate = tg; e_tlen = tl; e_err = er;
                    e_valid = 1'b1;
                    m_have_prev = 1'b1;
                end
                q_s.delete();
                q_g.delete();
                m_active = 1'b1;
            end
            m_sp = s;
            if (m_active) begin
                q_s.push_back(s);
                q_g.push_back(g);
            end
        end
    endtask

    task automatic compare_all();
        if (p_valid) vcnt++;
        chk("p_tsync", 32'(p_tsync), 32'(e_tsync));
        chk("p_tgdel", 32'(p_tgdel), 32'(e_tgdel));
        chk("p_tgate", 32'(p_tgate), 32'(e_tgate));
        chk("p_tlen", 32'(p_tlen), 32'(e_tlen));
        chk("p_valid", 32'(p_valid), 32'(e_valid));
        chk("p_stable", 32'(p_stable), 32'(e_stable));
        chk("p_err", 32'(p_err), 32'(e_err));
        chk("n_tsync", 32'(n_tsync), 32'(e_tsync));
        chk("n_tgdel", 32'(n_tgdel), 32'(e_tgdel));
        chk("n_tgate", 32'(n_tgate), 32'(e_tgate));
        chk("n_tlen", 32'(n_tlen), 32'(e_tlen));
        chk("n_valid", 32'(n_valid), 32'(e_valid));
        chk("n_stable", 32'(n_stable), 32'(e_stable));
        chk("n_err", 32'(n_err), 32'(e_err));
    endtask

    task automatic step(input logic e, input logic s, input logic g);
        ena = e;
        sync_a = s;
        gate_a = g;
        model_step(e, s, g);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ena = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;
    endtask

    // One ena sample, preceded by per-1 disabled clocks carrying junk inputs.
    task automatic sample(input logic s, input logic g, input int per);
        for (int k = 1; k < per; k++)
            step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        step(1'b1, s, g);
    endtask

    task automatic frame(input int ns, input int nd, input int ng, input int nt,
                         input int per, input bit gs);
        for (int i = 0; i < ns; i++) sample(1'b1, 1'(gs && i == 1), per);
        for (int i = 0; i < nd; i++) sample(1'b0, 1'b0, per);
        for (int i = 0; i < ng; i++) sample(1'b0, 1'b1, per);
        for (int i = 0; i < nt; i++) sample(1'b0, 1'b0, per);
    endtask

    task automatic chk_vals(input string tag, input int ts, input int td, input int tg,
                            input int tl, input int er, input int st);
        chk({tag, "_tsync"}, 32'(p_tsync), 32'(ts));
        chk({tag, "_tgdel"}, 32'(p_tgdel), 32'(td));
        chk({tag, "_tgate"}, 32'(p_tgate), 32'(tg));
        chk({tag, "_tlen"}, 32'(p_tlen), 32'(tl));
        chk({tag, "_err"}, 32'(p_err), 32'(er));
        chk({tag, "_stable"}, 32'(p_stable), 32'(st));
    endtask

    initial begin
        int v0;
        do_reset();
        chk_vals("rst", 0, 0, 0, 0, 0, 0);
        chk("rst_valid", 32'(p_valid), 32'd0);

        // basic frames, ena always on
        sample(1'b0, 1'b0, 1);
        v0 = vcnt;
        repeat (5) frame(4, 3, 10, 5, 1, 1'b0);
        chk("basic_valid_cnt", 32'(vcnt - v0), 32'd4);
        chk_vals("basic", 3, 2, 9, 21, 0, 1);

        // ena on every third clock
        repeat (4) frame(4, 3, 10, 5, 3, 1'b0);
        chk_vals("ena3", 3, 2, 9, 21, 0, 1);

        // gate asserted during sync
        frame(4, 3, 10, 5, 1, 1'b1);
        frame(4, 3, 10, 5, 1, 1'b0);
        chk_vals("gsync_bad", 3, 2, 9, 21, 1, 0);
        frame(4, 3, 10, 5, 1, 1'b0);
        chk_vals("gsync_clean1", 3, 2, 9, 21, 0, 0);
        frame(4, 3, 10, 5, 1, 1'b0);
        chk_vals("gsync_clean2", 3, 2, 9, 21, 0, 1);

        // long sync saturates
        frame(300, 3, 10, 5, 1, 1'b0);
        frame(4, 3, 10, 5, 1, 1'b0);
        chk_vals("longsync", 255, 2, 9, 317, 1, 0);

        // reset in the middle of the gate
        frame(4, 3, 5, 0, 1, 1'b0);
        do_reset();
        chk_vals("midrst", 0, 0, 0, 0, 0, 0);
        sample(1'b0, 1'b0, 1);
        v0 = vcnt;
        frame(4, 3, 10, 5, 1, 1'b0);
        chk("midrst_novalid", 32'(vcnt - v0), 32'd0);
        frame(4, 3, 10, 5, 1, 1'b0);
        chk("midrst_valid", 32'(vcnt - v0), 32'd1);
        chk_vals("midrst_vals", 3, 2, 9, 21, 0, 0);

        // randomized frames, including zero delay, missing gate, uneven ena
        for (int f = 0; f < 60; f++) begin
            frame($urandom_range(1, 6), $urandom_range(0, 4), $urandom_range(0, 12),
                  $urandom_range(0, 5), $urandom_range(1, 3), 1'($urandom_range(0, 5) == 0));
        end
        frame(4, 3, 10, 5, 1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
